// File: rtl/fc_layer_sequencer.sv
// Single-MAC fully-connected layer sequencer. For each output neuron it clears the core,
// streams N (node, weight) pairs from the operand SRAMs, waits for the sum and hands it downstream.
module fc_layer_sequencer #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int NODE_ADDR_W   = 10,
  parameter int OUT_ADDR_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [NODE_ADDR_W:0]              i_num_node,
  input  logic [OUT_ADDR_W:0]               i_num_out,
  output logic                              o_idle,
  output logic                              o_done,
  output logic                              o_node_rd_en,
  output logic [NODE_ADDR_W-1:0]            o_node_addr,
  input  logic [IN_DATA_WIDTH-1:0]          i_node_data,
  output logic                              o_wegt_rd_en,
  output logic [NODE_ADDR_W+OUT_ADDR_W-1:0] o_wegt_addr,
  input  logic [IN_DATA_WIDTH-1:0]          i_wegt_data,
  output logic                              o_core_run,
  output logic                              o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]          o_core_node,
  output logic [IN_DATA_WIDTH-1:0]          o_core_wegt,
  input  logic                              i_core_valid,
  input  logic [4*IN_DATA_WIDTH-1:0]        i_core_result,
  output logic                              o_res_valid,
  input  logic                              i_res_ready,
  output logic [OUT_ADDR_W-1:0]             o_res_addr,
  output logic [4*IN_DATA_WIDTH-1:0]        o_res_data
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE} state_t;

  state_t                 state;
  logic [NODE_ADDR_W:0]   num_node;
  logic [OUT_ADDR_W:0]    num_out;
  logic [NODE_ADDR_W:0]   vld_cnt;
  logic [NODE_ADDR_W:0]   node_last;
  logic [OUT_ADDR_W:0]    out_last;

  assign node_last    = num_node - (NODE_ADDR_W+1)'(1);
  assign out_last     = num_out - (OUT_ADDR_W+1)'(1);
  assign o_wegt_rd_en = o_node_rd_en;
  assign o_core_node  = i_node_data;
  assign o_core_wegt  = i_wegt_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      num_node     <= '0;
      num_out      <= '0;
      vld_cnt      <= '0;
      o_idle       <= 1'b1;
      o_done       <= 1'b0;
      o_node_rd_en <= 1'b0;
      o_node_addr  <= '0;
      o_wegt_addr  <= '0;
      o_core_run   <= 1'b0;
      o_core_valid <= 1'b0;
      o_res_valid  <= 1'b0;
      o_res_addr   <= '0;
      o_res_data   <= '0;
    end else begin
      // a read issued in the abort cycle is dropped so the core never sees it
      o_core_valid <= o_node_rd_en & ~i_abort;
      o_core_run   <= 1'b0;
      o_done       <= 1'b0;
      if (i_abort) begin
        state        <= IDLE;
        o_idle       <= 1'b1;
        o_core_run   <= 1'b1;
        o_node_rd_en <= 1'b0;
        o_res_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              o_idle <= 1'b0;
              if (i_num_node != '0 && i_num_out != '0) begin
                state       <= CLEAR;
                o_core_run  <= 1'b1;
                num_node    <= i_num_node;
                num_out     <= i_num_out;
                o_res_addr  <= '0;
                o_wegt_addr <= '0;
              end else begin
                state  <= DONE;
                o_done <= 1'b1;
              end
            end
          end
          CLEAR: begin
            state        <= FEED;
            o_node_rd_en <= 1'b1;
            o_node_addr  <= '0;
            vld_cnt      <= '0;
          end
          FEED: begin
            o_node_addr <= o_node_addr + NODE_ADDR_W'(1);
            o_wegt_addr <= o_wegt_addr + (NODE_ADDR_W+OUT_ADDR_W)'(1);
            // with deep N, early core pulses already arrive while still feeding
            if (i_core_valid) vld_cnt <= vld_cnt + (NODE_ADDR_W+1)'(1);
            if ({1'b0, o_node_addr} == node_last) begin
              o_node_rd_en <= 1'b0;
              state        <= DRAIN;
            end
          end
          DRAIN: begin
            if (i_core_valid) begin
              if (vld_cnt == node_last) begin
                o_res_data  <= i_core_result;
                o_res_valid <= 1'b1;
                state       <= OUTPUT;
              end else begin
                vld_cnt <= vld_cnt + (NODE_ADDR_W+1)'(1);
              end
            end
          end
          OUTPUT: begin
            if (i_res_ready) begin
              o_res_valid <= 1'b0;
              if ({1'b0, o_res_addr} == out_last) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                o_res_addr <= o_res_addr + OUT_ADDR_W'(1);
                o_core_run <= 1'b1;
                state      <= CLEAR;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            o_idle <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            o_idle <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized bench for fc_layer_sequencer: behavioural SRAMs and MAC core, expected sums
// computed as plain dot products, one per-cycle compare process plus directed literal checks.
module tb_fc_layer_sequencer;
  localparam int W = 8, NA = 10, OA = 8, RW = 4 * W;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic            i_start = 1'b0, i_abort = 1'b0, i_res_ready = 1'b0;
  logic [NA:0]     i_num_node = '0;
  logic [OA:0]     i_num_out = '0;
  logic            o_idle, o_done, o_node_rd_en, o_wegt_rd_en, o_core_run, o_core_valid, o_res_valid;
  logic [NA-1:0]   o_node_addr;
  logic [NA+OA-1:0] o_wegt_addr;
  logic [W-1:0]    i_node_data, i_wegt_data, o_core_node, o_core_wegt;
  logic            i_core_valid;
  logic [RW-1:0]   i_core_result, o_res_data;
  logic [OA-1:0]   o_res_addr;

  always #5 clk = ~clk;

  fc_layer_sequencer #(.IN_DATA_WIDTH(W), .NODE_ADDR_W(NA), .OUT_ADDR_W(OA)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_num_node(i_num_node), .i_num_out(i_num_out), .o_idle(o_idle), .o_done(o_done),
    .o_node_rd_en(o_node_rd_en), .o_node_addr(o_node_addr), .i_node_data(i_node_data),
    .o_wegt_rd_en(o_wegt_rd_en), .o_wegt_addr(o_wegt_addr), .i_wegt_data(i_wegt_data),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid), .o_core_node(o_core_node),
    .o_core_wegt(o_core_wegt), .i_core_valid(i_core_valid), .i_core_result(i_core_result),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_addr(o_res_addr),
    .o_res_data(o_res_data)
  );

  // operand SRAMs (1-cycle read) and a 2-stage MAC core
  logic [W-1:0]  node_mem [0:1023];
  logic [W-1:0]  wegt_mem [0:2047];
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [RW-1:0] p1 = '0, acc = '0;
  always @(posedge clk) begin
    if (o_node_rd_en) begin
      i_node_data <= node_mem[o_node_addr];
      i_wegt_data <= wegt_mem[o_wegt_addr[10:0]];
    end
    v1 <= o_core_valid;
    p1 <= RW'(o_core_node) * RW'(o_core_wegt);
    v2 <= v1;
    if (o_core_run) acc <= '0;
    else if (v1) acc <= acc + p1;
  end
  assign i_core_valid  = v2;
  assign i_core_result = acc;

  int vec = 0, mis = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // model state shared by stimulus and compare process
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] res_log [0:7];
  logic [RW-1:0] last_data = '0, prev_data = '0, e;
  logic [OA-1:0] prev_addr = '0;
  int  cur_n = 1, exp_rd = 0, run_cnt = 0, done_cnt = 0, res_cnt = 0, res_hi = 0;
  int  first_res_cyc = -1, done_cyc = -1, s_cyc = 0;
  int  rmode = 0, hold_left = 0;
  bit  mon_en = 1'b0, prev_rd = 1'b0, prev_abort = 1'b0, prev_cv = 1'b0, prev_hold = 1'b0;

  initial forever begin
    @(posedge clk); #2;
    case (rmode)
      0: i_res_ready = 1'b1;
      1: i_res_ready = 1'($urandom % 2);
      default: if (o_res_valid && hold_left > 0) begin i_res_ready = 1'b0; hold_left--; end
               else i_res_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!reset_n || !mon_en) begin
      prev_rd = 0; prev_abort = 0; prev_cv = 0; prev_hold = 0;
    end else begin
      chk("core_valid", o_core_valid, prev_rd && !prev_abort);
      if (o_core_valid && exp_rd > 0) begin
        chk("core_node", o_core_node, node_mem[(exp_rd - 1) % cur_n]);
        chk("core_wegt", o_core_wegt, wegt_mem[exp_rd - 1]);
      end
      if (prev_abort) begin
        chk("abort_run", o_core_run, 1); chk("abort_idle", o_idle, 1);
        chk("abort_rd", o_node_rd_en, 0); chk("abort_res", o_res_valid, 0);
      end else if (o_core_run) begin
        chk("run_inflight", {prev_cv, o_core_valid}, 0);
      end
      if (o_core_run) run_cnt++;
      if (o_node_rd_en) begin
        chk("node_addr", o_node_addr, exp_rd % cur_n);
        chk("wegt_addr", o_wegt_addr, exp_rd);
        chk("wegt_rd_en", o_wegt_rd_en, 1);
        exp_rd++;
      end else if (o_wegt_rd_en) chk("wegt_rd_en", o_wegt_rd_en, 0);
      if (o_res_valid) begin
        res_hi++;
        if (first_res_cyc < 0) first_res_cyc = cyc;
        if (prev_hold) begin
          chk("hold_data", o_res_data, prev_data);
          chk("hold_addr", o_res_addr, prev_addr);
        end
        if (i_res_ready) begin
          if (exp_q.size() == 0) chk("unexpected_res", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("res_data", o_res_data, e);
            chk("res_addr", o_res_addr, res_cnt);
          end
          if (res_cnt < 8) res_log[res_cnt] = o_res_data;
          last_data = o_res_data;
          res_cnt++;
        end
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (i_abort) exp_q.delete();
      prev_hold = o_res_valid && !i_res_ready;
      prev_data = o_res_data; prev_addr = o_res_addr;
      prev_rd = o_node_rd_en; prev_abort = i_abort; prev_cv = o_core_valid;
    end
  end

  task automatic start_layer(input int n, input int m);
    longint s;
    exp_q.delete();
    if (n > 0 && m > 0)
      for (int j = 0; j < m; j++) begin
        s = 0;
        for (int i = 0; i < n; i++) s += longint'(node_mem[i]) * longint'(wegt_mem[j * n + i]);
        exp_q.push_back(RW'(s));
      end
    cur_n = (n == 0) ? 1 : n;
    exp_rd = 0; run_cnt = 0; done_cnt = 0; res_cnt = 0; res_hi = 0;
    first_res_cyc = -1; done_cyc = -1;
    @(posedge clk); #2;
    i_num_node = (NA+1)'(n); i_num_out = (OA+1)'(m); i_start = 1'b1; s_cyc = cyc;
    @(posedge clk); #2;
    i_start = 1'b0;
  endtask

  task automatic run_layer(input int n, input int m, input int rm, input bit noise);
    int k, limit;
    rmode = rm; hold_left = (rm == 2) ? 5 : 0;
    start_layer(n, m);
    limit = m * (n + 5) * 8 + 50; k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(posedge clk); k++;
      if (done_cnt == 0) begin
        #2;
        i_start = noise && (k % 97 == 50);
        if (i_start) begin i_num_node = (NA+1)'($urandom); i_num_out = (OA+1)'($urandom); end
      end
    end
    #2 i_start = 1'b0;
    if (done_cnt == 0) chk("timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("res_cnt", res_cnt, (n == 0 || m == 0) ? 0 : m);
    chk("reads", exp_rd, n * m);
    chk("run_pulses", run_cnt, (n == 0 || m == 0) ? 0 : m);
    chk("exp_left", exp_q.size(), 0);
    chk("idle_end", o_idle, 1);
    if (n == 0 || m == 0) chk("done_lat", done_cyc - s_cyc, 1);
    else if (rm == 0) begin
      chk("res_lat", first_res_cyc - s_cyc, n + 5);
      chk("done_lat", done_cyc - s_cyc, m * (n + 5) + 1);
    end
  endtask

  task automatic fill_rand(input int n, input int m);
    for (int i = 0; i < n; i++) node_mem[i] = W'($urandom);
    for (int i = 0; i < n * m; i++) wegt_mem[i] = W'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", o_idle, 1); chk("rst_done", o_done, 0); chk("rst_rd", o_node_rd_en, 0);
    chk("rst_run", o_core_run, 0); chk("rst_cv", o_core_valid, 0); chk("rst_resv", o_res_valid, 0);
    chk("rst_data", o_res_data, 0); chk("rst_waddr", o_wegt_addr, 0);
    #1 reset_n = 1'b1; mon_en = 1'b1;

    for (int i = 0; i < 4; i++) begin node_mem[i] = W'(i + 1); wegt_mem[i] = W'(i + 5); end
    run_layer(4, 1, 0, 0);
    chk("t1_sum70", last_data, 70);

    for (int i = 0; i < 3; i++) node_mem[i] = 8'd1;
    for (int i = 0; i < 6; i++) wegt_mem[i] = W'(i + 1);
    run_layer(3, 2, 0, 0);
    chk("t2_sum6", res_log[0], 6); chk("t2_sum15", res_log[1], 15);

    fill_rand(2, 2);
    run_layer(2, 2, 2, 0);
    chk("t3_hold_cycles", res_hi, 7);

    run_layer(0, 3, 0, 0);
    run_layer(5, 0, 0, 0);
    fill_rand(1, 3);
    run_layer(1, 3, 0, 0);

    // abort while feeding neuron 0, at read index 3
    fill_rand(8, 2);
    start_layer(8, 2);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (o_node_rd_en && o_node_addr == 3) begin i_abort = 1'b1; break; end
    end
    @(posedge clk); #2 i_abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("ab_done", done_cnt, 0); chk("ab_res", res_cnt, 0);
    chk("ab_runs", run_cnt, 2); chk("ab_idle", o_idle, 1);
    run_layer(8, 2, 1, 0);

    // abort and start together in IDLE: abort wins
    exp_rd = 0; run_cnt = 0;
    @(posedge clk); #2;
    i_num_node = 11'd4; i_num_out = 9'd1; i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #2 i_start = 1'b0; i_abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("as_idle", o_idle, 1); chk("as_reads", exp_rd, 0); chk("as_runs", run_cnt, 1);

    // reset mid-layer, then a normal layer
    fill_rand(8, 2);
    start_layer(8, 2);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_idle", o_idle, 1); chk("mr_rd", o_node_rd_en, 0); chk("mr_waddr", o_wegt_addr, 0);
    chk("mr_run", o_core_run, 0); chk("mr_resv", o_res_valid, 0); chk("mr_done", o_done, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    exp_q.delete();
    fill_rand(6, 3);
    run_layer(6, 3, 0, 0);

    for (int t = 0; t < 6; t++) begin
      int n, m;
      n = $urandom_range(1, 24); m = $urandom_range(1, 4);
      fill_rand(n, m);
      run_layer(n, m, 1, 0);
    end

    for (int i = 0; i < 1024; i++) begin node_mem[i] = 8'hFF; wegt_mem[i] = 8'hFF; end
    run_layer(1024, 1, 0, 1);
    chk("big_sum", last_data, 66585600);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
